char_bbox_locate: RTL and testbench

Per-frame character bounding-box locator that sits directly upstream of the single-character recognition stage. Thresholds the incoming video stream, accumulates the extent of foreground (dark) pixels over one frame, and at frame end publishes a margin-padded box (`hcount_l/r`, `vcount_l/r`) plus a 3-bit `frame_cnt`. The video stream is forwarded with one cycle of delay so the recognition stage sees aligned pixels and box coordinates.

---
 rtl/char_bbox_locate.sv | 178 +++++++++++++++++
 tb/tb_char_bbox_locate.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_bbox_locate.sv
// Per-frame character bounding-box locator: thresholds video, tracks foreground extent,
// publishes a margin-padded box at each vsync. Optional border overlay: CHAR_BBOX_OVERLAY_EN.
module char_bbox_locate #(
  parameter logic [11:0] H_ACTIVE  = 12'd640,
  parameter logic [11:0] V_ACTIVE  = 12'd480,
  parameter logic [7:0]  FG_THRESH = 8'd128,
  parameter logic [19:0] MIN_PIX   = 20'd16,
  parameter logic [11:0] MARGIN    = 12'd2
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [23:0] i_rgb,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        bbox_valid,
  output logic [2:0]  frame_cnt
);

  // state  | meaning
  // IDLE   | after reset, accumulators held clear until first vsync edge
  // ACCUM  | accumulating foreground extent for the current frame
  // LATCH  | one cycle: publish box, clear accumulators
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LATCH} state_t;

  state_t state_q, state_d;

  logic        vs_q;
  logic        vs_rise;
  logic        qual;
  logic [11:0] min_h_q, min_h_d, max_h_q, max_h_d;
  logic [11:0] min_v_q, min_v_d, max_v_q, max_v_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
  logic        valid_q, valid_d;
  logic [2:0]  fc_q, fc_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, de_q;
  logic [12:0] hr_ext, vr_ext;
  logic [11:0] h_max, v_max;

  assign h_max   = H_ACTIVE - 12'd1;
  assign v_max   = V_ACTIVE - 12'd1;
  assign vs_rise = i_vsync & ~vs_q;
  assign qual    = i_de && (hcount < H_ACTIVE) && (vcount < V_ACTIVE)
                   && (i_rgb[15:8] < FG_THRESH);

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (vs_rise) state_d = S_ACCUM;
      S_ACCUM: if (vs_rise) state_d = S_LATCH;
      S_LATCH: state_d = S_ACCUM;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulators only move in ACCUM; IDLE and LATCH both leave them clear.
  always_comb begin
    min_h_d   = min_h_q;
    max_h_d   = max_h_q;
    min_v_d   = min_v_q;
    max_v_d   = max_v_q;
    pix_cnt_d = pix_cnt_q;
    if (state_q != S_ACCUM) begin
      min_h_d   = 12'hFFF;
      max_h_d   = 12'd0;
      min_v_d   = 12'hFFF;
      max_v_d   = 12'd0;
      pix_cnt_d = 20'd0;
    end else if (qual) begin
      if (hcount < min_h_q) min_h_d = hcount;
      if (hcount > max_h_q) max_h_d = hcount;
      if (vcount < min_v_q) min_v_d = vcount;
      if (vcount > max_v_q) max_v_d = vcount;
      if (pix_cnt_q != 20'hFFFFF) pix_cnt_d = pix_cnt_q + 20'd1;
    end
  end

  // Right/bottom edges computed one bit wider so the margin cannot wrap.
  assign hr_ext = {1'b0, max_h_q} + {1'b0, MARGIN};
  assign vr_ext = {1'b0, max_v_q} + {1'b0, MARGIN};

  always_comb begin
    hl_d    = hl_q;
    hr_d    = hr_q;
    vl_d    = vl_q;
    vr_d    = vr_q;
    valid_d = valid_q;
    fc_d    = fc_q;
    if (state_q == S_LATCH) begin
      fc_d = fc_q + 3'd1;
      if (pix_cnt_q >= MIN_PIX) begin
        hl_d    = (min_h_q >= MARGIN) ? min_h_q - MARGIN : 12'd0;
        vl_d    = (min_v_q >= MARGIN) ? min_v_q - MARGIN : 12'd0;
        hr_d    = (hr_ext > {1'b0, h_max}) ? h_max : hr_ext[11:0];
        vr_d    = (vr_ext > {1'b0, v_max}) ? v_max : vr_ext[11:0];
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

`ifdef CHAR_BBOX_OVERLAY_EN
  logic in_hspan, in_vspan, on_col, on_row;
  assign in_hspan = (hcount >= hl_q) && (hcount <= hr_q);
  assign in_vspan = (vcount >= vl_q) && (vcount <= vr_q);
  assign on_col   = ((hcount == hl_q) || (hcount == hr_q)) && in_vspan;
  assign on_row   = ((vcount == vl_q) || (vcount == vr_q)) && in_hspan;
  assign rgb_d    = (i_de && valid_q && (on_col || on_row)) ? 24'hFF0000 : i_rgb;
`else
  assign rgb_d    = i_rgb;
`endif

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      vs_q      <= 1'b0;
      min_h_q   <= 12'hFFF;
      max_h_q   <= 12'd0;
      min_v_q   <= 12'hFFF;
      max_v_q   <= 12'd0;
      pix_cnt_q <= 20'd0;
      hl_q      <= 12'd0;
      hr_q      <= h_max;
      vl_q      <= 12'd0;
      vr_q      <= v_max;
      valid_q   <= 1'b0;
      fc_q      <= 3'd0;
      rgb_q     <= 24'd0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      vs_q      <= i_vsync;
      min_h_q   <= min_h_d;
      max_h_q   <= max_h_d;
      min_v_q   <= min_v_d;
      max_v_q   <= max_v_d;
      pix_cnt_q <= pix_cnt_d;
      hl_q      <= hl_d;
      hr_q      <= hr_d;
      vl_q      <= vl_d;
      vr_q      <= vr_d;
      valid_q   <= valid_d;
      fc_q      <= fc_d;
      rgb_q     <= rgb_d;
      hs_q      <= i_hsync;
      de_q      <= i_de;
    end
  end

  assign o_rgb      = rgb_q;
  assign o_hsync    = hs_q;
  assign o_vsync    = vs_q;
  assign o_de       = de_q;
  assign hcount_l   = hl_q;
  assign hcount_r   = hr_q;
  assign vcount_l   = vl_q;
  assign vcount_r   = vr_q;
  assign bbox_valid = valid_q;
  assign frame_cnt  = fc_q;

endmodule

// File: tb/tb_char_bbox_locate.sv
// Scoreboard bench for char_bbox_locate: a behavioural box model pushes expected
// publishes at each vsync edge; they are popped and compared two cycles later.
module tb_char_bbox_locate;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [23:0] i_rgb;
  logic        i_hsync, i_vsync, i_de;
  logic [11:0] hcount, vcount;
  logic [23:0] o_rgb;
  logic        o_hsync, o_vsync, o_de;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic        bbox_valid;
  logic [2:0]  frame_cnt;

  char_bbox_locate dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .i_rgb(i_rgb), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .hcount(hcount), .vcount(vcount),
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
    .bbox_valid(bbox_valid), .frame_cnt(frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [11:0] hl, hr, vl, vr;
    logic        valid;
    logic [2:0]  fc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_accum;
  int m_minh, m_maxh, m_minv, m_maxv, m_cnt;
  int m_hl, m_hr, m_vl, m_vr, m_fc;
  bit m_valid;

  task automatic tick();
    @(posedge pixel_clk); #1;
  endtask

  task automatic model_clear();
    m_minh = 4095; m_maxh = 0; m_minv = 4095; m_maxv = 0; m_cnt = 0;
  endtask

  function automatic bit overlay_hit(input int h, input int v, input bit de);
`ifdef CHAR_BBOX_OVERLAY_EN
    bit hs, vs;
    hs = (h >= m_hl) && (h <= m_hr);
    vs = (v >= m_vl) && (v <= m_vr);
    return de && m_valid && ((((h == m_hl) || (h == m_hr)) && vs) ||
                             (((v == m_vl) || (v == m_vr)) && hs));
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_pix(input int h, input int v, input bit dark, input bit de);
    logic [23:0] rgb, exp_rgb;
    logic [7:0]  g;
    bit          hs;
    g   = dark ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
    rgb = {8'($urandom_range(0, 255)), g, 8'($urandom_range(0, 255))};
    hs  = 1'($urandom_range(0, 1));
    i_rgb = rgb; i_de = de; hcount = 12'(h); vcount = 12'(v); i_hsync = hs;
    if (m_accum && de && h < 640 && v < 480 && dark) begin
      if (h < m_minh) m_minh = h;
      if (h > m_maxh) m_maxh = h;
      if (v < m_minv) m_minv = v;
      if (v > m_maxv) m_maxv = v;
      m_cnt++;
    end
    exp_rgb = overlay_hit(h, v, de) ? 24'hFF0000 : rgb;
    tick();
    n_cmp++;
    if (o_rgb !== exp_rgb) begin
      n_bad++; $display("FAIL o_rgb (h=%0d v=%0d): got %h expected %h", h, v, o_rgb, exp_rgb);
    end
    n_cmp++;
    if (o_de !== de || o_hsync !== hs) begin
      n_bad++; $display("FAIL o_de/o_hsync: got %b/%b expected %b/%b", o_de, o_hsync, de, hs);
    end
    i_de = 1'b0;
  endtask

  task automatic drive_block(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) drive_pix(h, v, 1'b1, 1'b1);
  endtask

  task automatic vsync_edge();
    exp_t e;
    bit   pub;
    int   prev_fc;
    prev_fc = m_fc;
    pub = m_accum;
    if (pub) begin
      m_fc = (m_fc + 1) % 8;
      if (m_cnt >= 16) begin
        m_hl = (m_minh >= 2) ? m_minh - 2 : 0;
        m_vl = (m_minv >= 2) ? m_minv - 2 : 0;
        m_hr = (m_maxh + 2 > 639) ? 639 : m_maxh + 2;
        m_vr = (m_maxv + 2 > 479) ? 479 : m_maxv + 2;
        m_valid = 1'b1;
      end else m_valid = 1'b0;
      e = '{hl: 12'(m_hl), hr: 12'(m_hr), vl: 12'(m_vl), vr: 12'(m_vr),
            valid: m_valid, fc: 3'(m_fc)};
      sb.push_back(e);
    end
    m_accum = 1'b1;
    model_clear();
    i_vsync = 1'b1; i_de = 1'b0;
    tick();
    n_cmp++;
    if (o_vsync !== 1'b1 || frame_cnt !== 3'(prev_fc)) begin
      n_bad++; $display("FAIL latch_cycle: o_vsync=%b frame_cnt=%0d expected 1/%0d", o_vsync, frame_cnt, prev_fc);
    end
    i_vsync = 1'b0;
    tick();
    if (pub) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = sb.pop_front();
        if ({hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, frame_cnt} !== e) begin
          n_bad++;
          $display("FAIL publish: got l=%0d r=%0d t=%0d b=%0d v=%b fc=%0d expected l=%0d r=%0d t=%0d b=%0d v=%b fc=%0d",
                   hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, frame_cnt,
                   e.hl, e.hr, e.vl, e.vr, e.valid, e.fc);
        end
      end
    end else begin
      n_cmp++;
      if (frame_cnt !== 3'(m_fc) || bbox_valid !== m_valid || hcount_l !== 12'(m_hl) || hcount_r !== 12'(m_hr)) begin
        n_bad++;
        $display("FAIL idle_no_publish: got fc=%0d v=%b l=%0d r=%0d expected fc=%0d v=%b l=%0d r=%0d",
                 frame_cnt, bbox_valid, hcount_l, hcount_r, m_fc, m_valid, m_hl, m_hr);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    m_accum = 1'b0; model_clear();
    m_hl = 0; m_hr = 639; m_vl = 0; m_vr = 479; m_valid = 1'b0; m_fc = 0;
    n_cmp++;
    if (hcount_l !== 12'd0 || hcount_r !== 12'd639 || vcount_l !== 12'd0 || vcount_r !== 12'd479) begin
      n_bad++; $display("FAIL reset_box: got %0d %0d %0d %0d expected 0 639 0 479", hcount_l, hcount_r, vcount_l, vcount_r);
    end
    n_cmp++;
    if (bbox_valid !== 1'b0 || frame_cnt !== 3'd0) begin
      n_bad++; $display("FAIL reset_status: got v=%b fc=%0d expected 0/0", bbox_valid, frame_cnt);
    end
    n_cmp++;
    if (o_rgb !== 24'd0 || o_hsync !== 1'b0 || o_vsync !== 1'b0 || o_de !== 1'b0) begin
      n_bad++; $display("FAIL reset_video: got rgb=%h hs=%b vs=%b de=%b expected zeros", o_rgb, o_hsync, o_vsync, o_de);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rgb = 24'hFFFFFF; i_hsync = 1'b1; i_vsync = 1'b0; i_de = 1'b1;
    hcount = 12'd0; vcount = 12'd0;
    do_reset();
  endtask

  task automatic test_basic_box();
    drive_block(10, 13, 10, 13);          // partial frame before first edge: ignored
    vsync_edge();
    drive_block(100, 119, 50, 79);
    drive_pix(700, 60, 1'b1, 1'b1);       // off-screen dark pixel
    drive_pix(5, 5, 1'b1, 1'b0);          // dark but not enabled
    drive_pix(200, 200, 1'b0, 1'b1);      // bright
    vsync_edge();                         // expect 98,121,48,81 valid fc=1
  endtask

  task automatic test_overlay();
    drive_pix(98, 60, 1'b0, 1'b1);
    drive_pix(97, 60, 1'b0, 1'b1);
    drive_pix(110, 81, 1'b0, 1'b1);
    drive_pix(121, 48, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    drive_block(0, 9, 470, 479);
    vsync_edge();                         // 0,11,468,479
    drive_block(630, 639, 0, 1);
    vsync_edge();                         // 628,639,0,3
  endtask

  task automatic test_noise();
    for (int i = 0; i < 10; i++) drive_pix(30 * i + 5, 17 * i + 3, 1'b1, 1'b1);
    vsync_edge();                         // invalid, box held
    for (int i = 0; i < 16; i++) drive_pix(300 + 7 * i, 400 - 3 * i, 1'b1, 1'b1);
    vsync_edge();                         // exactly MIN_PIX: valid
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 9; f++) begin
      if (f % 2 == 0)
        for (int i = 0; i < 16; i++)
          drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1);
      vsync_edge();
    end
  endtask

  task automatic test_back_to_back();
    drive_block(200, 219, 200, 200);
    vsync_edge();
    vsync_edge();                         // empty frame: invalid, box held
  endtask

  task automatic test_midframe_reset();
    drive_block(50, 59, 50, 51);
    do_reset();
    drive_block(60, 69, 60, 61);          // IDLE: ignored
    vsync_edge();                         // no publish
    drive_block(400, 409, 300, 301);
    vsync_edge();                         // fc=1
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_basic_box();
    test_overlay();
    test_clamp();
    test_noise();
    test_wrap();
    test_back_to_back();
    test_midframe_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
